// File: rtl/dma_pkg.sv
// dma_pkg: shared state type, priority-mode constants and round-robin helper
// for the DMA write arbiter.
package dma_pkg;
    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
    localparam logic PRIO_RR    = 1'b0;
    localparam logic PRIO_FIXED = 1'b1;
    localparam int   MAX_CH     = 8;
    // Returns {valid, index} of the first request after ptr, wrapping at n.
    function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] req, input logic [2:0] ptr, input int n);
        logic [3:0] res;
        logic [2:0] c;
        res = '0;
        for (int d = MAX_CH; d >= 1; d--) begin
            if (d <= n) begin
                c = 3'((int'(ptr) + d) % n);
                if (req[c]) res = {1'b1, c};
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/dma_arb_picker.sv
// dma_arb_picker: combinational winner selection; fixed priority is a
// round-robin search that starts just after the last channel.
module dma_arb_picker
    import dma_pkg::*;
#(
    parameter int N_CH = 3,
    parameter int IW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    input  logic            mode_i,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);
    logic [3:0] pick;
    always_comb pick = rr_pick(MAX_CH'(req_i), mode_i == PRIO_FIXED ? 3'(N_CH - 1) : 3'(ptr_i), N_CH);
    assign idx_o   = IW'(pick[2:0]);
    assign valid_o = pick[3];
endmodule

// File: rtl/dma_wr_arbiter.sv
// dma_wr_arbiter: N-channel Avalon-MM write arbiter onto one SDRAM write port
// with round-robin/fixed priority, per-channel base offset, burst lock and beat counters.
module dma_wr_arbiter
    import dma_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int DATA_W    = 128,
    parameter int ADR_W     = 28,
    parameter int BURST_MAX = 16,
    parameter int CNT_W     = 16,
    localparam int IW       = $clog2(N_CH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  prio_mode_i,
    input  logic [N_CH*DATA_W-1:0] ch_data_i,
    input  logic [N_CH*ADR_W-1:0] ch_adr_i,
    input  logic [N_CH*ADR_W-1:0] ch_base_i,
    input  logic [N_CH-1:0]       ch_wr_i,
    output logic [N_CH-1:0]       ch_waitreq_o,
    output logic [DATA_W-1:0]     sdram_writedata_o,
    output logic [ADR_W-1:0]      sdram_address_o,
    output logic                  sdram_write_o,
    input  logic                  sdram_waitrequest_i,
    output logic [IW-1:0]         grant_idx_o,
    output logic [N_CH*CNT_W-1:0] beat_cnt_o
);
    arb_state_e       state_q;
    logic [IW-1:0]    grant_q, ptr_q, pick_idx;
    logic             pick_valid, wr_g, accept, release_g;
    logic [7:0]       burst_q, burst_d;
    logic [CNT_W-1:0] beat_q [N_CH];

    dma_arb_picker #(.N_CH(N_CH), .IW(IW)) u_picker (
        .req_i   (ch_wr_i),
        .ptr_i   (ptr_q),
        .mode_i  (prio_mode_i),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // A stalled beat keeps ch_wr high, so it can never satisfy either release condition.
    always_comb begin
        wr_g      = state_q == ARB_GRANT && ch_wr_i[grant_q];
        accept    = wr_g && !sdram_waitrequest_i;
        burst_d   = accept ? burst_q + 8'd1 : burst_q;
        release_g = state_q == ARB_GRANT && (!ch_wr_i[grant_q] || (accept && burst_d == 8'(BURST_MAX)));
        ch_waitreq_o = '1;
        if (state_q == ARB_GRANT) ch_waitreq_o[grant_q] = sdram_waitrequest_i;
    end

    assign sdram_write_o     = wr_g;
    assign sdram_writedata_o = ch_data_i[int'(grant_q)*DATA_W +: DATA_W];
    assign sdram_address_o   = ch_adr_i[int'(grant_q)*ADR_W +: ADR_W] + ch_base_i[int'(grant_q)*ADR_W +: ADR_W];
    assign grant_idx_o       = grant_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_cnt
        assign beat_cnt_o[i*CNT_W +: CNT_W] = beat_q[i];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= IW'(N_CH - 1);
            burst_q <= '0;
            for (int i = 0; i < N_CH; i++) beat_q[i] <= '0;
        end else if (state_q == ARB_IDLE) begin
            if (pick_valid) begin
                grant_q <= pick_idx;
                state_q <= ARB_GRANT;
            end
        end else begin
            burst_q <= release_g ? '0 : burst_d;
            if (accept) beat_q[grant_q] <= beat_q[grant_q] + CNT_W'(1);
            if (release_g) begin
                state_q <= ARB_IDLE;
                ptr_q   <= grant_q;
            end
        end
    end
endmodule

// File: tb/tb_dma_wr_arbiter.sv
// tb_dma_wr_arbiter: two arbiters (burst 16 and burst 4) driven by bench masters,
// checked every cycle against a transaction-level ownership model.
module tb_dma_wr_arbiter;
    localparam int N = 3, DW = 32, AW = 28, CW = 16, IW = 2;

    logic clk = 1'b0;
    logic rst;
    logic mode [2];
    logic [N*DW-1:0] dat [2];
    logic [N*AW-1:0] adr [2], base [2];
    logic [N-1:0] wr [2], wq [2];
    logic sreq [2], swr [2];
    logic [DW-1:0] sdat [2];
    logic [AW-1:0] sadr [2];
    logic [IW-1:0] gidx [2];
    logic [N*CW-1:0] bcnt [2];

    always #5 clk = ~clk;

    dma_wr_arbiter #(.N_CH(N), .DATA_W(DW), .ADR_W(AW), .BURST_MAX(16), .CNT_W(CW)) u_b16 (
        .clk_i(clk), .rst_i(rst), .prio_mode_i(mode[0]), .ch_data_i(dat[0]), .ch_adr_i(adr[0]),
        .ch_base_i(base[0]), .ch_wr_i(wr[0]), .ch_waitreq_o(wq[0]), .sdram_writedata_o(sdat[0]),
        .sdram_address_o(sadr[0]), .sdram_write_o(swr[0]), .sdram_waitrequest_i(sreq[0]),
        .grant_idx_o(gidx[0]), .beat_cnt_o(bcnt[0]));

    dma_wr_arbiter #(.N_CH(N), .DATA_W(DW), .ADR_W(AW), .BURST_MAX(4), .CNT_W(CW)) u_b4 (
        .clk_i(clk), .rst_i(rst), .prio_mode_i(mode[1]), .ch_data_i(dat[1]), .ch_adr_i(adr[1]),
        .ch_base_i(base[1]), .ch_wr_i(wr[1]), .ch_waitreq_o(wq[1]), .sdram_writedata_o(sdat[1]),
        .sdram_address_o(sadr[1]), .sdram_write_o(swr[1]), .sdram_waitrequest_i(sreq[1]),
        .grant_idx_o(gidx[1]), .beat_cnt_o(bcnt[1]));

    int n_chk = 0, n_err = 0;
    // masters: rem beats left (-1 = endless), seq = accepted beats, data carries seq
    int rem [2][N];
    logic [15:0] seq [2][N], rx_seq [2][N];
    logic [AW-1:0] adr_off [2][N], base_v [2][N];
    int wq_pct [2], stall_left [2];
    bit long_en;
    // reference model: who owns the bus, beats in this burst, last owner
    bit m_busy [2];
    int m_g [2], m_ptr [2], m_burst [2];
    int m_cnt [2][N];
    bit e_acc [2], prev_stall [2], prev_w [2];
    logic [IW-1:0] prev_g [2];
    logic [DW-1:0] prev_dat [2];
    bit s_write [2];
    logic [AW-1:0] s_addr [2];
    logic [IW-1:0] s_g [2];
    logic [N-1:0] s_wq [2];
    int gq [$];

    function automatic int bm(input int k);
        return k == 0 ? 16 : 4;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm, input string why);
        n_chk++;
        n_err++;
        $display("FAIL %s: %s at %0t", nm, why, $time);
    endtask

    function automatic int pick(input int k);
        int c;
        for (int d = 1; d <= N; d++) begin
            c = mode[k] ? d - 1 : (m_ptr[k] + d) % N;
            if (wr[k][c]) return c;
        end
        return -1;
    endfunction

    task automatic master_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                rem[k][i] = 0;
                seq[k][i] = '0;
                rx_seq[k][i] = '0;
            end
            stall_left[k] = 0;
            wq_pct[k] = 0;
            mode[k] = 1'b0;
        end
        long_en = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_g[k] = 0; m_ptr[k] = N - 1; m_burst[k] = 0;
            for (int i = 0; i < N; i++) m_cnt[k][i] = 0;
            prev_stall[k] = 0; prev_w[k] = 0; s_write[k] = 0;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                dat[k][i*DW +: DW] = {8'(i), 8'(k), seq[k][i]};
                adr[k][i*AW +: AW] = adr_off[k][i];
                base[k][i*AW +: AW] = base_v[k][i];
                wr[k][i] = rem[k][i] != 0;
            end
            if (stall_left[k] > 0) begin
                sreq[k] = 1'b1;
                stall_left[k]--;
            end else if (long_en && $urandom_range(99) < 2) begin
                stall_left[k] = int'($urandom_range(150, 10)) - 1;
                sreq[k] = 1'b1;
            end else sreq[k] = int'($urandom_range(99)) < wq_pct[k];
        end
    endtask

    task automatic check_k(input int k);
        logic ew;
        logic [N-1:0] ewq;
        logic [N*CW-1:0] eb;
        logic [AW-1:0] ea;
        int ch;
        ew = m_busy[k] && wr[k][m_g[k]];
        ewq = '1;
        if (m_busy[k]) ewq[m_g[k]] = sreq[k];
        for (int i = 0; i < N; i++) eb[i*CW +: CW] = CW'(m_cnt[k][i]);
        chk($sformatf("grant_idx[%0d]", k), 64'(gidx[k]), 64'(m_g[k]));
        chk($sformatf("write[%0d]", k), 64'(swr[k]), 64'(ew));
        chk($sformatf("ch_waitreq[%0d]", k), 64'(wq[k]), 64'(ewq));
        chk($sformatf("beat_cnt[%0d]", k), 64'(bcnt[k]), 64'(eb));
        if (ew) begin
            ea = AW'((longint'(adr_off[k][m_g[k]]) + longint'(base_v[k][m_g[k]])) % (longint'(1) << AW));
            chk($sformatf("wdata[%0d]", k), 64'(sdat[k]), 64'({8'(m_g[k]), 8'(k), seq[k][m_g[k]]}));
            chk($sformatf("address[%0d]", k), 64'(sadr[k]), 64'(ea));
        end
        if (prev_stall[k]) begin
            chk($sformatf("stall_hold_grant[%0d]", k), 64'(gidx[k]), 64'(prev_g[k]));
            chk($sformatf("stall_hold_write[%0d]", k), 64'(swr[k]), 64'(1));
            chk($sformatf("stall_hold_data[%0d]", k), 64'(sdat[k]), 64'(prev_dat[k]));
        end
        if (swr[k] && !sreq[k]) begin
            ch = int'(sdat[k][31:24]);
            if (ch < N) begin
                chk($sformatf("seq_ch%0d[%0d]", ch, k), 64'(sdat[k][15:0]), 64'(rx_seq[k][ch]));
                rx_seq[k][ch]++;
            end else fail($sformatf("seq_ch[%0d]", k), "accepted beat tagged with a nonexistent channel");
        end
        if (k == 1 && swr[1] && !prev_w[1]) gq.push_back(int'(gidx[1]));
        prev_w[k] = swr[k];
        prev_stall[k] = swr[k] && sreq[k];
        prev_g[k] = gidx[k];
        prev_dat[k] = sdat[k];
        e_acc[k] = ew && !sreq[k];
        s_write[k] = swr[k]; s_addr[k] = sadr[k]; s_g[k] = gidx[k]; s_wq[k] = wq[k];
        for (int i = 0; i < N; i++) begin
            if (wr[k][i] && !wq[k][i]) begin
                seq[k][i]++;
                if (rem[k][i] > 0) rem[k][i]--;
            end
        end
    endtask

    task automatic upd(input int k);
        int c;
        if (m_busy[k]) begin
            if (e_acc[k]) begin
                m_burst[k]++;
                m_cnt[k][m_g[k]] = (m_cnt[k][m_g[k]] + 1) % 65536;
            end
            if (!wr[k][m_g[k]] || (e_acc[k] && m_burst[k] == bm(k))) begin
                m_busy[k] = 0; m_ptr[k] = m_g[k]; m_burst[k] = 0;
            end
        end else begin
            c = pick(k);
            if (c >= 0) begin
                m_busy[k] = 1; m_g[k] = c;
            end
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_k(k);
        @(posedge clk);
        for (int k = 0; k < 2; k++) upd(k);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_write[%0d]", k), 64'(swr[k]), 64'(0));
            chk($sformatf("rst_waitreq[%0d]", k), 64'(wq[k]), 64'(3'b111));
            chk($sformatf("rst_grant[%0d]", k), 64'(gidx[k]), 64'(0));
            chk($sformatf("rst_beat_cnt[%0d]", k), 64'(bcnt[k]), 64'(0));
        end
        master_reset();
        model_reset();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        int ch;
        logic [AW-1:0] base, adr, exp;
    } vec_t;

    initial begin
        vec_t tbl [5];
        int runs [$], gaps [$];
        int cur, gap, total, cmin, cmax, cv, t;
        bit found, busy;
        tbl[0] = '{2, 28'hFFFFFFF, 28'h0000002, 28'h0000001};
        tbl[1] = '{0, 28'h0000010, 28'h0000020, 28'h0000030};
        tbl[2] = '{1, 28'h8000000, 28'h8000000, 28'h0000000};
        tbl[3] = '{2, 28'hFFFFFFF, 28'hFFFFFFF, 28'hFFFFFFE};
        tbl[4] = '{1, 28'h1234567, 28'h0ABCDEF, 28'h1CF1356};
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) begin
                adr_off[k][i] = AW'(i * 'h100 + 'h40);
                base_v[k][i] = AW'(k * 'h1000 + i * 'h10);
            end
        master_reset();
        model_reset();
        drive();
        do_reset();

        // address offset and wrap vectors, one single-beat transfer each
        foreach (tbl[r]) begin
            adr_off[1][tbl[r].ch] = tbl[r].adr;
            base_v[1][tbl[r].ch] = tbl[r].base;
            rem[1][tbl[r].ch] = 1;
            found = 0;
            for (int s = 0; s < 6 && !found; s++) begin
                step();
                if (s_write[1]) begin
                    chk($sformatf("tbl_addr%0d", r), 64'(s_addr[1]), 64'(tbl[r].exp));
                    found = 1;
                end
            end
            if (!found) fail($sformatf("tbl_addr%0d", r), "no write strobe within 6 cycles");
            step();
            step();
        end

        // single master, 40 beats through the burst-16 arbiter
        do_reset();
        rem[0][1] = 40;
        cur = 0; gap = 0;
        repeat (60) begin
            step();
            if (s_write[0]) begin
                if (gap > 0) gaps.push_back(gap);
                gap = 0;
                cur++;
            end else begin
                if (cur > 0) runs.push_back(cur);
                if (cur > 0 || gap > 0 || runs.size() > 0) gap++;
                cur = 0;
            end
        end
        chk("b16_runs", 64'(runs.size()), 64'(3));
        if (runs.size() == 3) begin
            chk("b16_run0", 64'(runs[0]), 64'(16));
            chk("b16_run1", 64'(runs[1]), 64'(16));
            chk("b16_run2", 64'(runs[2]), 64'(8));
        end
        if (gaps.size() >= 2) begin
            chk("b16_gap0", 64'(gaps[0]), 64'(1));
            chk("b16_gap1", 64'(gaps[1]), 64'(1));
        end else fail("b16_gaps", "fewer than two idle gaps between bursts");
        chk("b16_cnt1", 64'(bcnt[0][CW +: CW]), 64'(40));

        // all channels requesting, round-robin, burst 4
        do_reset();
        for (int i = 0; i < N; i++) rem[1][i] = -1;
        gq.delete();
        total = 0; t = 0;
        while (total < 120 && t < 300) begin
            step();
            t++;
            total = m_cnt[1][0] + m_cnt[1][1] + m_cnt[1][2];
        end
        if (total < 120) fail("rr_beats", "120 beats not reached within 300 cycles");
        for (int j = 0; j < gq.size(); j++) chk($sformatf("rr_order%0d", j), 64'(gq[j]), 64'(j % 3));
        cmin = 1 << 30; cmax = 0;
        for (int i = 0; i < N; i++) begin
            cv = int'(bcnt[1][i*CW +: CW]);
            cmin = cv < cmin ? cv : cmin;
            cmax = cv > cmax ? cv : cmax;
        end
        chk("rr_balance_spread_le4", 64'(cmax - cmin <= 4), 64'(1));

        // fixed priority: ch0 keeps the bus
        do_reset();
        mode[1] = 1'b1;
        for (int i = 0; i < N; i++) rem[1][i] = -1;
        repeat (40) begin
            step();
            chk("fix_waitreq12", 64'(s_wq[1][2:1]), 64'(2'b11));
            if (s_write[1]) chk("fix_grant", 64'(s_g[1]), 64'(0));
        end

        // random traffic, backpressure with long stalls, mode flips
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) base_v[k][i] = AW'($urandom);
        long_en = 1; wq_pct[0] = 30; wq_pct[1] = 30;
        repeat (4000) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < N; i++)
                    if (rem[k][i] == 0 && $urandom_range(99) < 10) rem[k][i] = int'($urandom_range(40, 1));
                if ($urandom_range(99) < 2) mode[k] = ~mode[k];
            end
            step();
        end
        long_en = 0; wq_pct[0] = 0; wq_pct[1] = 0;
        t = 0; busy = 1;
        while (busy && t < 1000) begin
            step();
            t++;
            busy = 0;
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < N; i++) if (rem[k][i] != 0) busy = 1;
        end
        if (busy) fail("rand_drain", "masters did not finish within 1000 cycles");
        step();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++)
                chk($sformatf("rand_cnt_vs_src[%0d][%0d]", k, i), 64'(bcnt[k][i*CW +: CW]), 64'(seq[k][i]));

        // reset during a stalled beat on ch1, then ch0 wins first
        do_reset();
        wq_pct[1] = 100;
        rem[1][1] = -1;
        repeat (3) step();
        chk("pre_rst_grant", 64'(s_g[1]), 64'(1));
        chk("pre_rst_write", 64'(s_write[1]), 64'(1));
        #2;
        do_reset();
        for (int i = 0; i < N; i++) rem[1][i] = -1;
        step();
        step();
        chk("post_rst_grant", 64'(s_g[1]), 64'(0));
        chk("post_rst_write", 64'(s_write[1]), 64'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
